// File: rtl/ch_inst_sequencer.sv
// ch_inst_sequencer: chip-level START/STOP/READOUT pulse sequencer for the channel sampling state machines
package ch_inst_pkg;
  typedef enum logic [1:0] {
    MODE_SAMPLE4 = 2'd0,
    MODE_SAMPLE2 = 2'd1,
    MODE_SAMPLE1 = 2'd2,
    MODE_SAMPLE8 = 2'd3
  } smode_t;
endpackage

module ch_inst_sequencer
  import ch_inst_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int DLY_W   = 8,
  parameter int TMO_W   = 16,
  parameter int BLANK   = 3
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             HOST_START,
  input  logic             HOST_STOP,
  input  logic             HOST_READOUT,
  input  logic             AUTO_READOUT,
  input  smode_t           MODE,
  input  logic [DLY_W-1:0] STOP_DELAY,
  input  logic             STOP_REQUEST,
  input  logic             READOUT_DONE,
  output logic             INST_START,
  output logic             INST_STOP,
  output logic             INST_READOUT,
  output smode_t           MODE_OUT,
  output logic             BUSY,
  output logic [2:0]       SEQ_STATE,
  output logic [15:0]      EVT_CNT,
  output logic             TIMEOUT
);
  localparam int PW = $clog2(PULSE_W + BLANK + 1);
  localparam int CA = (TMO_W > DLY_W) ? TMO_W : DLY_W;
  localparam int CW = (CA > PW) ? CA : PW;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'((2 ** TMO_W) - 2);

  // RD_P is the readout pulse phase; it is reported to the host as STOPPED
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START_P = 4'd1,
    ARMING  = 4'd2,
    ARMED   = 4'd3,
    DELAY   = 4'd4,
    STOP_P  = 4'd5,
    STOPPED = 4'd6,
    READOUT = 4'd7,
    RD_P    = 4'd8
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DLY_W-1:0] dly_lat;
  logic sr_meta, sr_sync;
  logic start_acc, done_hit, tmo_hit;

  assign start_acc = (state_n == START_P) && (state != START_P);
  assign done_hit  = (state == READOUT) && READOUT_DONE;
  assign tmo_hit   = (state == READOUT) && !READOUT_DONE && (cnt == TMO_LAST);
  assign BUSY      = state != IDLE;
  assign SEQ_STATE = (state == RD_P) ? 3'd6 : state[2:0];

  // Next state and shared phase counter; a rising edge implies a high level, so the level test covers both
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    case (state)
      IDLE:    if (HOST_START) state_n = START_P;
      START_P: if (cnt == PULSE_LAST) state_n = ARMING;
      ARMING:  if (cnt == BLANK_LAST) state_n = ARMED;
      ARMED:   state_n = HOST_STOP ? STOP_P : (sr_sync ? DELAY : ARMED);
      DELAY: begin
        cnt_n = cnt - CW'(1);
        if (HOST_STOP || cnt == '0) state_n = STOP_P;
      end
      STOP_P:  if (cnt == PULSE_LAST) state_n = STOPPED;
      STOPPED: state_n = (HOST_READOUT || AUTO_READOUT) ? RD_P : (HOST_START ? START_P : STOPPED);
      RD_P:    if (cnt == PULSE_LAST) state_n = READOUT;
      READOUT: if (READOUT_DONE || cnt == TMO_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = (state_n == DELAY) ? CW'(dly_lat) : '0;
  end

  // State, synchronizer, registered pulses, latched configuration and status
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state        <= IDLE;
      cnt          <= '0;
      dly_lat      <= '0;
      sr_meta      <= 1'b0;
      sr_sync      <= 1'b0;
      INST_START   <= 1'b0;
      INST_STOP    <= 1'b0;
      INST_READOUT <= 1'b0;
      MODE_OUT     <= MODE_SAMPLE4;
      EVT_CNT      <= '0;
      TIMEOUT      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sr_meta      <= STOP_REQUEST;
      sr_sync      <= sr_meta;
      INST_START   <= state_n == START_P;
      INST_STOP    <= state_n == STOP_P;
      INST_READOUT <= state_n == RD_P;
      MODE_OUT     <= start_acc ? MODE : MODE_OUT;
      dly_lat      <= start_acc ? STOP_DELAY : dly_lat;
      TIMEOUT      <= start_acc ? 1'b0 : (tmo_hit | TIMEOUT);
      EVT_CNT      <= (done_hit && EVT_CNT != 16'hFFFF) ? EVT_CNT + 16'd1 : EVT_CNT;
    end
  end
endmodule

// File: tb/tb_ch_inst_sequencer.sv
// tb_ch_inst_sequencer: scenario bench with a pulse scoreboard for ch_inst_sequencer
module tb_ch_inst_sequencer;
  import ch_inst_pkg::*;
  localparam int PULSE_W = 4;
  localparam int DLY_W   = 8;
  localparam int TMO_W   = 4;
  localparam int BLANK   = 3;
  localparam logic [2:0] K_START = 3'b001;
  localparam logic [2:0] K_STOP  = 3'b010;
  localparam logic [2:0] K_RD    = 3'b100;

  logic CLK = 1'b0;
  logic RSTB = 1'b0;
  logic HOST_START = 1'b0, HOST_STOP = 1'b0, HOST_READOUT = 1'b0, AUTO_READOUT = 1'b0;
  smode_t MODE = MODE_SAMPLE4;
  logic [DLY_W-1:0] STOP_DELAY = '0;
  logic STOP_REQUEST = 1'b0, READOUT_DONE = 1'b0;
  logic INST_START, INST_STOP, INST_READOUT, BUSY, TIMEOUT;
  smode_t MODE_OUT;
  logic [2:0] SEQ_STATE;
  logic [15:0] EVT_CNT;

  int checks = 0;
  int failures = 0;
  int exp_evt = 0;
  int rd_idx = 0;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  int obs_w[$];
  logic [2:0] mon_cur;
  logic [2:0] mon_prev = '0;
  int mon_w = 0;
  bit overlap_seen = 1'b0;

  always #5 CLK = ~CLK;

  ch_inst_sequencer #(.PULSE_W(PULSE_W), .DLY_W(DLY_W), .TMO_W(TMO_W), .BLANK(BLANK)) dut (
    .CLK(CLK), .RSTB(RSTB), .HOST_START(HOST_START), .HOST_STOP(HOST_STOP),
    .HOST_READOUT(HOST_READOUT), .AUTO_READOUT(AUTO_READOUT), .MODE(MODE),
    .STOP_DELAY(STOP_DELAY), .STOP_REQUEST(STOP_REQUEST), .READOUT_DONE(READOUT_DONE),
    .INST_START(INST_START), .INST_STOP(INST_STOP), .INST_READOUT(INST_READOUT),
    .MODE_OUT(MODE_OUT), .BUSY(BUSY), .SEQ_STATE(SEQ_STATE), .EVT_CNT(EVT_CNT), .TIMEOUT(TIMEOUT)
  );

  assign mon_cur = {INST_READOUT, INST_STOP, INST_START};

  // Records every completed pulse (kind, width); a reset abandons the pulse in flight
  always @(negedge CLK) begin
    if (!RSTB) begin
      mon_prev <= '0;
      mon_w <= 0;
    end else begin
      if (!$onehot0(mon_cur) || (mon_cur != 3'b0 && mon_prev != 3'b0 && mon_cur != mon_prev)) overlap_seen <= 1'b1;
      if (mon_cur != 3'b0) mon_w <= mon_w + 1;
      else if (mon_prev != 3'b0) begin
        obs_q.push_back(mon_prev);
        obs_w.push_back(mon_w);
        mon_w <= 0;
      end
      mon_prev <= mon_cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output int n);
    n = 0;
    while (SEQ_STATE !== s && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_host(input bit st, input bit sp, input bit rd);
    HOST_START = st;
    HOST_STOP = sp;
    HOST_READOUT = rd;
    tick();
    HOST_START = 1'b0;
    HOST_STOP = 1'b0;
    HOST_READOUT = 1'b0;
  endtask

  // Scoreboard: pop each expected pulse against the next recorded pulse
  task automatic check_pulses(input string tag);
    logic [2:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        failures++;
        $display("FAIL %s_pulse got=none exp=kind%b", tag, e);
      end else begin
        if (obs_q[rd_idx] !== e || obs_w[rd_idx] != PULSE_W) begin
          failures++;
          $display("FAIL %s_pulse got=kind%b/w%0d exp=kind%b/w%0d", tag, obs_q[rd_idx], obs_w[rd_idx], e, PULSE_W);
        end
        rd_idx++;
      end
    end
    checks++;
    if (rd_idx != obs_q.size()) begin
      failures++;
      $display("FAIL %s_extra_pulses got=%0d exp=0", tag, obs_q.size() - rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    tick(2);
    checks++;
    if ({INST_START, INST_STOP, INST_READOUT, BUSY, TIMEOUT} !== 5'b0 || SEQ_STATE !== 3'd0 || EVT_CNT !== 16'd0 || MODE_OUT !== MODE_SAMPLE4) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b%b st=%0d evt=%0d mode=%0d exp=all0", INST_START, INST_STOP, INST_READOUT, BUSY, TIMEOUT, SEQ_STATE, EVT_CNT, MODE_OUT);
    end
    RSTB = 1'b1;
    tick();
    MODE = MODE_SAMPLE2;
    pulse_host(1'b1, 1'b0, 1'b0);
    checks++;
    if (INST_START !== 1'b1 || SEQ_STATE !== 3'd1 || MODE_OUT !== MODE_SAMPLE2) begin
      failures++;
      $display("FAIL reset_start_pulse got=%b st=%0d mode=%0d exp=1 st=1 mode=1", INST_START, SEQ_STATE, MODE_OUT);
    end
    tick();
    RSTB = 1'b0;
    #1;
    checks++;
    if (INST_START !== 1'b0 || SEQ_STATE !== 3'd0 || EVT_CNT !== 16'd0 || BUSY !== 1'b0 || MODE_OUT !== MODE_SAMPLE4) begin
      failures++;
      $display("FAIL reset_mid_pulse got=start%b st=%0d evt=%0d busy=%b mode=%0d exp=0/0/0/0/0", INST_START, SEQ_STATE, EVT_CNT, BUSY, MODE_OUT);
    end
    tick(2);
    RSTB = 1'b1;
    tick();
  endtask

  task automatic test_full_cycle();
    int n;
    MODE = MODE_SAMPLE2;
    STOP_DELAY = 8'd5;
    AUTO_READOUT = 1'b1;
    exp_q.push_back(K_START);
    exp_q.push_back(K_STOP);
    exp_q.push_back(K_RD);
    pulse_host(1'b1, 1'b0, 1'b0);
    wait_state(3'd3, 20, n);
    checks++;
    if (SEQ_STATE !== 3'd3 || n != PULSE_W + BLANK) begin
      failures++;
      $display("FAIL full_arm_time got=st%0d/%0d exp=st3/%0d", SEQ_STATE, n, PULSE_W + BLANK);
    end
    tick(10);
    checks++;
    if (SEQ_STATE !== 3'd3) begin
      failures++;
      $display("FAIL full_armed_hold got=%0d exp=3", SEQ_STATE);
    end
    STOP_REQUEST = 1'b1;
    tick();
    n = 0;
    while (INST_STOP !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 + 1 + 5 || SEQ_STATE !== 3'd5) begin
      failures++;
      $display("FAIL full_stop_latency got=%0d st=%0d exp=8 st=5", n, SEQ_STATE);
    end
    STOP_REQUEST = 1'b0;
    n = 0;
    while (INST_READOUT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (INST_READOUT !== 1'b1 || SEQ_STATE !== 3'd6) begin
      failures++;
      $display("FAIL full_readout_pulse got=rd%b st=%0d exp=rd1 st=6", INST_READOUT, SEQ_STATE);
    end
    wait_state(3'd7, 20, n);
    checks++;
    if (SEQ_STATE !== 3'd7) begin
      failures++;
      $display("FAIL full_readout_state got=%0d exp=7", SEQ_STATE);
    end
    // Done arrives 12 cycles in, inside the bench's 4-bit (15-cycle) timeout
    tick(11);
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    exp_evt++;
    checks++;
    if (SEQ_STATE !== 3'd0 || EVT_CNT !== 16'(exp_evt) || BUSY !== 1'b0 || TIMEOUT !== 1'b0 || MODE_OUT !== MODE_SAMPLE2) begin
      failures++;
      $display("FAIL full_end got=st%0d evt%0d busy%b tmo%b mode%0d exp=st0 evt%0d busy0 tmo0 mode1", SEQ_STATE, EVT_CNT, BUSY, TIMEOUT, MODE_OUT, exp_evt);
    end
    tick(2);
    check_pulses("full");
  endtask

  task automatic test_stale_request();
    int n;
    AUTO_READOUT = 1'b0;
    STOP_REQUEST = 1'b1;
    tick(3);
    exp_q.push_back(K_START);
    pulse_host(1'b1, 1'b0, 1'b0);
    n = 0;
    while ((SEQ_STATE === 3'd1 || SEQ_STATE === 3'd2) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (SEQ_STATE !== 3'd3 || n != PULSE_W + BLANK) begin
      failures++;
      $display("FAIL stale_blanking got=st%0d/%0d exp=st3/%0d", SEQ_STATE, n, PULSE_W + BLANK);
    end
    tick();
    checks++;
    if (SEQ_STATE !== 3'd4) begin
      failures++;
      $display("FAIL stale_first_armed got=%0d exp=4", SEQ_STATE);
    end
    STOP_REQUEST = 1'b0;
    exp_q.push_back(K_STOP);
    pulse_host(1'b0, 1'b1, 1'b0);
    wait_state(3'd6, 20, n);
    checks++;
    if (SEQ_STATE !== 3'd6) begin
      failures++;
      $display("FAIL stale_stopped got=%0d exp=6", SEQ_STATE);
    end
    STOP_REQUEST = 1'b1;
    tick(3);
    exp_q.push_back(K_START);
    pulse_host(1'b1, 1'b0, 1'b0);
    tick();
    STOP_REQUEST = 1'b0;
    wait_state(3'd3, 20, n);
    tick(10);
    checks++;
    if (SEQ_STATE !== 3'd3) begin
      failures++;
      $display("FAIL stale_dropped got=%0d exp=3", SEQ_STATE);
    end
    exp_q.push_back(K_STOP);
    pulse_host(1'b0, 1'b1, 1'b0);
    wait_state(3'd6, 20, n);
    tick();
    check_pulses("stale");
  endtask

  task automatic test_force_stop();
    int n;
    STOP_DELAY = 8'd200;
    MODE = MODE_SAMPLE1;
    exp_q.push_back(K_START);
    pulse_host(1'b1, 1'b0, 1'b0);
    wait_state(3'd3, 20, n);
    STOP_REQUEST = 1'b1;
    wait_state(3'd4, 10, n);
    checks++;
    if (SEQ_STATE !== 3'd4) begin
      failures++;
      $display("FAIL force_delay got=%0d exp=4", SEQ_STATE);
    end
    STOP_REQUEST = 1'b0;
    tick(3);
    exp_q.push_back(K_STOP);
    pulse_host(1'b0, 1'b1, 1'b0);
    checks++;
    if (INST_STOP !== 1'b1 || SEQ_STATE !== 3'd5) begin
      failures++;
      $display("FAIL force_stop_now got=stop%b st=%0d exp=stop1 st=5", INST_STOP, SEQ_STATE);
    end
    wait_state(3'd6, 20, n);
    tick(10);
    checks++;
    if (SEQ_STATE !== 3'd6 || INST_READOUT !== 1'b0) begin
      failures++;
      $display("FAIL force_stopped_wait got=st%0d rd%b exp=st6 rd0", SEQ_STATE, INST_READOUT);
    end
    exp_q.push_back(K_RD);
    pulse_host(1'b0, 1'b0, 1'b1);
    checks++;
    if (INST_READOUT !== 1'b1 || SEQ_STATE !== 3'd6) begin
      failures++;
      $display("FAIL force_host_readout got=rd%b st=%0d exp=rd1 st=6", INST_READOUT, SEQ_STATE);
    end
    wait_state(3'd7, 20, n);
    tick(2);
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    exp_evt++;
    checks++;
    if (SEQ_STATE !== 3'd0 || EVT_CNT !== 16'(exp_evt) || MODE_OUT !== MODE_SAMPLE1) begin
      failures++;
      $display("FAIL force_done got=st%0d evt%0d mode%0d exp=st0 evt%0d mode2", SEQ_STATE, EVT_CNT, MODE_OUT, exp_evt);
    end
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    tick();
    checks++;
    if (EVT_CNT !== 16'(exp_evt) || SEQ_STATE !== 3'd0) begin
      failures++;
      $display("FAIL stray_done got=evt%0d st%0d exp=evt%0d st0", EVT_CNT, SEQ_STATE, exp_evt);
    end
    check_pulses("force");
  endtask

  task automatic test_timeout();
    int n;
    AUTO_READOUT = 1'b1;
    STOP_DELAY = 8'd0;
    exp_q.push_back(K_START);
    exp_q.push_back(K_STOP);
    exp_q.push_back(K_RD);
    pulse_host(1'b1, 1'b0, 1'b0);
    wait_state(3'd3, 20, n);
    STOP_REQUEST = 1'b1;
    wait_state(3'd4, 10, n);
    tick();
    checks++;
    if (SEQ_STATE !== 3'd5) begin
      failures++;
      $display("FAIL zero_delay got=%0d exp=5", SEQ_STATE);
    end
    STOP_REQUEST = 1'b0;
    wait_state(3'd7, 30, n);
    n = 0;
    while (SEQ_STATE !== 3'd0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != (2 ** TMO_W) - 1 || TIMEOUT !== 1'b1 || EVT_CNT !== 16'(exp_evt)) begin
      failures++;
      $display("FAIL timeout got=%0d tmo%b evt%0d exp=%0d tmo1 evt%0d", n, TIMEOUT, EVT_CNT, (2 ** TMO_W) - 1, exp_evt);
    end
    check_pulses("timeout");
    AUTO_READOUT = 1'b0;
    exp_q.push_back(K_START);
    pulse_host(1'b1, 1'b0, 1'b0);
    checks++;
    if (TIMEOUT !== 1'b0 || SEQ_STATE !== 3'd1) begin
      failures++;
      $display("FAIL timeout_clear got=tmo%b st%0d exp=tmo0 st1", TIMEOUT, SEQ_STATE);
    end
  endtask

  task automatic test_priority();
    int n;
    wait_state(3'd3, 20, n);
    exp_q.push_back(K_STOP);
    pulse_host(1'b1, 1'b1, 1'b1);
    checks++;
    if (SEQ_STATE !== 3'd5 || {INST_READOUT, INST_STOP, INST_START} !== K_STOP) begin
      failures++;
      $display("FAIL priority_stop got=st%0d pulses%b exp=st5 pulses010", SEQ_STATE, {INST_READOUT, INST_STOP, INST_START});
    end
    wait_state(3'd6, 20, n);
    tick(5);
    checks++;
    if (SEQ_STATE !== 3'd6 || INST_READOUT !== 1'b0) begin
      failures++;
      $display("FAIL priority_not_queued got=st%0d rd%b exp=st6 rd0", SEQ_STATE, INST_READOUT);
    end
    exp_q.push_back(K_RD);
    pulse_host(1'b1, 1'b0, 1'b1);
    checks++;
    if (SEQ_STATE !== 3'd6 || {INST_READOUT, INST_STOP, INST_START} !== K_RD) begin
      failures++;
      $display("FAIL back_to_back_readout got=st%0d pulses%b exp=st6 pulses100", SEQ_STATE, {INST_READOUT, INST_STOP, INST_START});
    end
    wait_state(3'd7, 20, n);
    READOUT_DONE = 1'b1;
    tick();
    READOUT_DONE = 1'b0;
    exp_evt++;
    checks++;
    if (EVT_CNT !== 16'(exp_evt) || SEQ_STATE !== 3'd0) begin
      failures++;
      $display("FAIL priority_done got=evt%0d st%0d exp=evt%0d st0", EVT_CNT, SEQ_STATE, exp_evt);
    end
    tick(2);
    check_pulses("priority");
    checks++;
    if (overlap_seen !== 1'b0) begin
      failures++;
      $display("FAIL pulse_overlap got=%b exp=0", overlap_seen);
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_stale_request();
    test_force_stop();
    test_timeout();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
